// File: rtl/pk_capture_pkg.sv
// pk_capture_pkg
//   Shared definitions for the packet-capture FIFO PIO: Avalon register
//   offsets, STATUS bit positions and a helper that packs the STATUS word.
package pk_capture_pkg;

  // Word offsets of the Avalon-MM slave registers.
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_ADDR   = 2'd1,
    REG_STATUS = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_off_e;

  // Bit positions inside the STATUS word.
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 8;

  // Assemble the STATUS read word; every bit not named here reads as zero.
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w                       = 32'h0000_0000;
    w[ST_EMPTY]             = empty;
    w[ST_FULL]              = full;
    w[ST_OVF]               = ovf;
    w[ST_CNT_LSB +: 8]      = cnt;
    return w;
  endfunction

endpackage

// File: rtl/pk_capture_fifo_pio_core.sv
// pk_fifo_core
//   Circular buffer of DEPTH entries with read/write pointers and an
//   occupancy count. When a push meets a full buffer without a pop, the
//   entry is either discarded (DROP_NEW=1) or written over the oldest entry
//   (DROP_NEW=0); either way a one-cycle overflow event is raised.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, wdata_i write request and entry to store
//   pop_i           remove head entry (ignored when empty)
//   rdata_o         current head entry (combinational)
//   empty_o/full_o  occupancy flags of the current state
//   count_o         current number of stored entries
//   empty_next_o    emptiness after this cycle's push/pop
//   ovf_evt_o       push rejected/overwrote because buffer was full
module pk_fifo_core #(
  parameter int unsigned ENTRY_W  = 40,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DROP_NEW = 1,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_next_o,
  output logic               ovf_evt_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               we_s;
  logic               pop_ok_s;
  logic               ovf_evt_s;
  logic               empty_s;
  logic               full_s;

  assign empty_s      = (count_q == {CNT_W{1'b0}});
  assign full_s       = (count_q == CNT_W'(DEPTH));
  assign rdata_o      = mem_q[rd_ptr_q];
  assign empty_o      = empty_s;
  assign full_o       = full_s;
  assign count_o      = count_q;
  assign empty_next_o = (count_d == {CNT_W{1'b0}});
  assign ovf_evt_o    = ovf_evt_s;

  // Next-state pointers, count and write enable, including full-buffer policy.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    we_s      = 1'b0;
    ovf_evt_s = 1'b0;
    pop_ok_s  = pop_i & ~empty_s;
    if (push_i && full_s && !pop_ok_s) begin
      ovf_evt_s = 1'b1;
      if (DROP_NEW != 0) begin
        we_s = 1'b0;
      end else begin
        // Overwrite oldest: the slot at wr_ptr is the head, so both advance.
        we_s     = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end
    end else begin
      if (push_i) begin
        we_s     = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        we_s     = 1'b0;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok_s);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (we_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/pk_capture_fifo_pio.sv
// pk_capture_fifo_pio
//   Captures {recv_addr, recv_data} on each packet-detect event into a FIFO
//   and exposes it to the NIOS through a 4-word Avalon-MM slave with a
//   maskable level interrupt (not-empty / overflow).
// Ports:
//   clk_clk, reset_reset_n   clock, asynchronous active-low reset
//   pk_detect                packet strobe
//   recv_addr, recv_data     packet contents, valid in the capture cycle
//   avs_*                    Avalon-MM slave, read latency 1
//   irq                      registered level interrupt
module pk_capture_fifo_pio
  import pk_capture_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned DROP_NEW  = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              pk_detect,
  input  logic [ADDR_W-1:0] recv_addr,
  input  logic [DATA_W-1:0] recv_data,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               pk_d_q;
  logic               ovf_q, ovf_d;
  logic [1:0]         irq_en_q, irq_en_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;

  logic               cap_s;
  logic               pop_s;
  logic               wr_en_s;
  logic [ENTRY_W-1:0] head_s;
  logic [DATA_W-1:0]  head_data_s;
  logic [ADDR_W-1:0]  head_addr_s;
  logic               empty_s;
  logic               full_s;
  logic [CNT_W-1:0]   count_s;
  logic               empty_next_s;
  logic               ovf_evt_s;
  logic               wdata_unused_s;

  assign cap_s       = (EDGE_MODE != 0) ? (pk_detect & ~pk_d_q) : pk_detect;
  assign pop_s       = avs_read & (avs_address == REG_DATA);
  // A simultaneous read takes priority and suppresses the write.
  assign wr_en_s     = avs_write & ~avs_read;
  assign head_data_s = head_s[DATA_W-1:0];
  assign head_addr_s = head_s[ENTRY_W-1 -: ADDR_W];
  assign wdata_unused_s = ^avs_writedata[31:3];

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

  pk_fifo_core #(
    .ENTRY_W  (ENTRY_W),
    .DEPTH    (DEPTH),
    .DROP_NEW (DROP_NEW)
  ) u_core (
    .clk_i        (clk_clk),
    .rst_ni       (reset_reset_n),
    .push_i       (cap_s),
    .wdata_i      ({recv_addr, recv_data}),
    .pop_i        (pop_s),
    .rdata_o      (head_s),
    .empty_o      (empty_s),
    .full_o       (full_s),
    .count_o      (count_s),
    .empty_next_o (empty_next_s),
    .ovf_evt_o    (ovf_evt_s)
  );

  // Read mux; readdata holds its value between reads.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        REG_DATA:   readdata_d = empty_s ? 32'h0000_0000 : 32'(head_data_s);
        REG_ADDR:   readdata_d = empty_s ? 32'h0000_0000 : 32'(head_addr_s);
        REG_STATUS: readdata_d = pack_status(empty_s, full_s, ovf_q, 8'(count_s));
        REG_IRQ_EN: readdata_d = {30'd0, irq_en_q};
        default:    readdata_d = 32'h0000_0000;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Overflow sticky flag (set beats clear) and interrupt-enable register.
  always_comb begin
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (wr_en_s && (avs_address == REG_STATUS) && avs_writedata[ST_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (wr_en_s && (avs_address == REG_IRQ_EN)) begin
      irq_en_d = avs_writedata[1:0];
    end else begin
      irq_en_d = irq_en_q;
    end
  end

  // Interrupt reflects the state after this cycle's updates.
  always_comb begin
    irq_d = (irq_en_d[0] & ~empty_next_s) | (irq_en_d[1] & ovf_d);
  end

  // Control/status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pk_d_q     <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 2'b00;
      readdata_q <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      pk_d_q     <= pk_detect;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_pk_capture_fifo_pio.sv
module tb_pk_capture_fifo_pio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pk_detect;
  logic [7:0]  recv_addr;
  logic [31:0] recv_data;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  always #5 clk = ~clk;

  // Drop-new instance
  pk_capture_fifo_pio #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .EDGE_MODE(1), .DROP_NEW(1)) u_drop (
    .clk_clk(clk), .reset_reset_n(rst_n), .pk_detect(pk_detect),
    .recv_addr(recv_addr), .recv_data(recv_data),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rd_a), .irq(irq_a));

  // Overwrite-oldest instance, driven by the same stimulus
  pk_capture_fifo_pio #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .EDGE_MODE(1), .DROP_NEW(0)) u_ovw (
    .clk_clk(clk), .reset_reset_n(rst_n), .pk_detect(pk_detect),
    .recv_addr(recv_addr), .recv_data(recv_data),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(rd_b), .irq(irq_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Avalon read; optionally a capture pulse rises in the same cycle.
  task automatic rd(input logic [1:0] a, input logic [31:0] ea, input logic [31:0] eb,
                    input bit with_pk, input string tag);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    avs_address = a;
    avs_read    = 1'b1;
    if (with_pk) pk_detect = 1'b1;
    tick();
    avs_read  = 1'b0;
    pk_detect = 1'b0;
    chk(rd_a, exp_a_q.pop_front(), {tag, "/drop"});
    chk(rd_b, exp_b_q.pop_front(), {tag, "/ovw"});
    if (with_pk) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] a, input logic [31:0] d);
    recv_addr = a;
    recv_data = d;
    pk_detect = 1'b1;
    tick();
    pk_detect = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; pk_detect = 1'b0; recv_addr = 8'h00; recv_data = 32'h0;
    avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'h0;
    repeat (3) tick();
    chk(rd_a, 32'h0, "rst_rdata_drop");
    chk(32'(irq_a), 32'h0, "rst_irq_drop");
    chk(32'(irq_b), 32'h0, "rst_irq_ovw");
    rst_n = 1'b1;
    tick();

    // Empty FIFO
    rd(2'd2, 32'h0000_0001, 32'h0000_0001, 1'b0, "status_empty");
    rd(2'd0, 32'h0, 32'h0, 1'b0, "data_empty");
    rd(2'd1, 32'h0, 32'h0, 1'b0, "addr_empty");
    rd(2'd2, 32'h0000_0001, 32'h0000_0001, 1'b0, "status_after_empty_pop");

    // Held strobe captures once in edge mode
    recv_addr = 8'h12; recv_data = 32'hDEAD_BEEF; pk_detect = 1'b1;
    repeat (5) tick();
    pk_detect = 1'b0;
    tick();
    rd(2'd2, 32'h0000_0100, 32'h0000_0100, 1'b0, "status_one");
    rd(2'd1, 32'h0000_0012, 32'h0000_0012, 1'b0, "addr_one");
    rd(2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "data_one");
    rd(2'd2, 32'h0000_0001, 32'h0000_0001, 1'b0, "status_drained");

    // Seventeen pulses into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) pulse(8'(i), 32'(i));
    rd(2'd2, 32'h0000_1006, 32'h0000_1006, 1'b0, "status_overflow");
    for (int i = 1; i <= 16; i++) rd(2'd0, 32'(i), 32'(i + 1), 1'b0, "data_ovf_seq");
    rd(2'd2, 32'h0000_0005, 32'h0000_0005, 1'b0, "status_ovf_sticky");
    wr(2'd0, 32'h0000_0004);
    rd(2'd2, 32'h0000_0005, 32'h0000_0005, 1'b0, "write_data_ignored");
    wr(2'd2, 32'h0000_0004);
    rd(2'd2, 32'h0000_0001, 32'h0000_0001, 1'b0, "status_ovf_cleared");

    // Not-empty interrupt
    wr(2'd3, 32'h0000_0001);
    tick();
    chk(32'(irq_a), 32'h0, "irq_idle_drop");
    chk(32'(irq_b), 32'h0, "irq_idle_ovw");
    pulse(8'h55, 32'hCAFE_0001);
    chk(32'(irq_a), 32'h1, "irq_set_drop");
    chk(32'(irq_b), 32'h1, "irq_set_ovw");
    rd(2'd3, 32'h0000_0001, 32'h0000_0001, 1'b0, "irq_en_rd");
    rd(2'd0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, "irq_pop");
    chk(32'(irq_a), 32'h0, "irq_clr_drop");
    chk(32'(irq_b), 32'h0, "irq_clr_ovw");

    // Overflow-only enable; simultaneous read+write keeps the register
    wr(2'd3, 32'h0000_0002);
    avs_writedata = 32'h0000_0003;
    avs_write = 1'b1;
    rd(2'd3, 32'h0000_0002, 32'h0000_0002, 1'b0, "rw_collide_rd");
    avs_write = 1'b0;
    rd(2'd3, 32'h0000_0002, 32'h0000_0002, 1'b0, "rw_collide_kept");

    // Full FIFO: push with simultaneous pop is not an overflow
    for (int i = 0; i < 16; i++) pulse(8'(8'h40 + i), 32'h100 + 32'(i));
    recv_addr = 8'h7F; recv_data = 32'h0000_0ABC;
    rd(2'd0, 32'h0000_0100, 32'h0000_0100, 1'b1, "full_push_pop");
    rd(2'd2, 32'h0000_1002, 32'h0000_1002, 1'b0, "full_no_ovf");
    chk(32'(irq_a), 32'h0, "irq_no_ovf_drop");
    chk(32'(irq_b), 32'h0, "irq_no_ovf_ovw");
    rd(2'd1, 32'h0000_0041, 32'h0000_0041, 1'b0, "head_addr_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
